// File: rtl/furnace_pkg.sv
// Shared definitions for the furnace sensor scan block: channel indices,
// the ADC open-circuit code, saturation limits, scan FSM encoding and
// the saturation helpers used when publishing filtered values.
package furnace_pkg;

    localparam logic [1:0] CH_CO   = 2'd0;
    localparam logic [1:0] CH_ETH  = 2'd1;
    localparam logic [1:0] CH_MF   = 2'd2;
    localparam logic [1:0] CH_TEMP = 2'd3;

    // An unconnected sensor makes the ADC rail to full scale.
    localparam logic [15:0] ADC_OPEN = 16'hFFFF;

    localparam logic [15:0] SAT_8BIT  = 16'd255;
    localparam logic [15:0] SAT_12BIT = 16'd4095;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_FILT = 3'd2,
        ST_NEXT = 3'd3,
        ST_PUB  = 3'd4
    } scan_state_t;

    function automatic logic [7:0] sat_8(input logic [15:0] v);
        return (v > SAT_8BIT) ? 8'hFF : v[7:0];
    endfunction

    function automatic logic [11:0] sat_12(input logic [15:0] v);
        return (v > SAT_12BIT) ? 12'hFFF : v[11:0];
    endfunction

endpackage

// File: rtl/furnace_sensor_scan_if.sv
// ADC request/acknowledge link between the scan block (master) and the
// converter (slave).
//
// Handshake: the master raises adc_req with adc_ch stable and holds both
// until it sees adc_ack or gives up on a timeout. The slave answers with a
// single-cycle adc_ack pulse; adc_data is valid only in that cycle. The
// master drops adc_req in the cycle after the ack. An ack while adc_req is
// low carries no meaning and is ignored.
interface furnace_sensor_scan_if;
    logic        adc_req;
    logic [1:0]  adc_ch;
    logic        adc_ack;
    logic [15:0] adc_data;

    modport master (output adc_req, output adc_ch, input adc_ack, input adc_data);
    modport slave  (input adc_req, input adc_ch, output adc_ack, output adc_data);
endinterface

// File: rtl/sensor_iir_filter.sv
// One channel of first-order IIR smoothing: y += (x - y) >>> FILT_SHIFT.
// The first accepted sample loads y directly so the output does not ramp
// up from zero after reset.
module sensor_iir_filter #(
    parameter int FILT_SHIFT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] x,
    output logic [15:0] y,
    output logic        primed
);

    logic signed [16:0] diff;
    logic signed [16:0] step;
    logic signed [16:0] sum;
    logic [15:0]        y_next;
    logic               sum_msb_unused;

    // 17-bit signed step; the result always lands back inside 0..65535.
    always_comb begin
        diff = $signed({1'b0, x}) - $signed({1'b0, y});
        step = diff >>> FILT_SHIFT;
        sum  = $signed({1'b0, y}) + step;
        {sum_msb_unused, y_next} = sum;
    end

    // Filter state: prime on the first sample, then track.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y      <= '0;
            primed <= 1'b0;
        end else if (en) begin
            if (!primed) begin
                y      <= x;
                primed <= 1'b1;
            end else begin
                y <= y_next;
            end
        end
    end

endmodule

// File: rtl/furnace_sensor_scan.sv
// Scans the four furnace ADC channels on a fixed period, smooths each one,
// saturates to the controller's widths and maintains a persistence-filtered
// fault flag from ADC timeouts and open-circuit codes.
module furnace_sensor_scan
    import furnace_pkg::*;
#(
    parameter int SCAN_DIV      = 1000,
    parameter int ACK_TIMEOUT   = 64,
    parameter int FILT_SHIFT    = 2,
    parameter int FAULT_PERSIST = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    furnace_sensor_scan_if.master        adc,
    output logic [7:0]                   CO,
    output logic [7:0]                   ethanol,
    output logic [11:0]                  massflow,
    output logic [15:0]                  temperature,
    output logic                         fault,
    output logic                         sample_valid,
    output logic [3:0]                   chan_err,
    output logic [2:0]                   state_dbg
);

    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  TO_LAST   = 8'(ACK_TIMEOUT - 1);
    localparam logic [3:0]  PERSIST_M1 = 4'(FAULT_PERSIST - 1);

    scan_state_t state;
    logic [15:0] scan_cnt;
    logic        tick;
    logic [7:0]  to_cnt;
    logic [1:0]  ch;
    logic        adc_req_q;
    logic [15:0] cap;
    logic [3:0]  err;
    logic [3:0]  bad_cnt;
    logic [3:0]  good_cnt;
    logic [3:0]  filt_en;
    logic [15:0] y [4];
    logic [3:0]  primed;

    assign adc.adc_req = adc_req_q;
    assign adc.adc_ch  = ch;
    assign state_dbg   = state;
    assign tick        = (scan_cnt == SCAN_LAST);

    // Free-running scan period counter; tick marks the wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
        end else if (tick) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + 16'd1;
        end
    end

    // Only the channel being filtered advances, and an open-circuit code
    // never reaches the filter.
    always_comb begin
        filt_en = '0;
        if (state == ST_FILT && cap != ADC_OPEN) begin
            filt_en[ch] = 1'b1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_filt
        sensor_iir_filter #(.FILT_SHIFT(FILT_SHIFT)) u_filt (
            .clk    (clk),
            .reset  (reset),
            .en     (filt_en[i]),
            .x      (cap),
            .y      (y[i]),
            .primed (primed[i])
        );
    end

    // Scan sequencer with registered ADC request, outputs and fault filter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            to_cnt       <= '0;
            ch           <= '0;
            adc_req_q    <= 1'b0;
            cap          <= '0;
            err          <= '0;
            bad_cnt      <= '0;
            good_cnt     <= '0;
            CO           <= '0;
            ethanol      <= '0;
            massflow     <= '0;
            temperature  <= '0;
            fault        <= 1'b0;
            sample_valid <= 1'b0;
            chan_err     <= '0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Ticks arriving mid-scan are simply not seen here.
                    if (tick) begin
                        ch        <= CH_CO;
                        err       <= '0;
                        to_cnt    <= '0;
                        adc_req_q <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (adc.adc_ack) begin
                        cap       <= adc.adc_data;
                        adc_req_q <= 1'b0;
                        state     <= ST_FILT;
                    end else if (to_cnt == TO_LAST) begin
                        err[ch]   <= 1'b1;
                        adc_req_q <= 1'b0;
                        state     <= ST_NEXT;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                ST_FILT: begin
                    if (cap == ADC_OPEN) begin
                        err[ch] <= 1'b1;
                    end
                    state <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (ch == CH_TEMP) begin
                        state <= ST_PUB;
                    end else begin
                        ch        <= ch + 2'd1;
                        to_cnt    <= '0;
                        adc_req_q <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_PUB: begin
                    // Errored or never-primed channels keep their last value.
                    if (!err[CH_CO] && primed[CH_CO])
                        CO <= sat_8(y[CH_CO]);
                    if (!err[CH_ETH] && primed[CH_ETH])
                        ethanol <= sat_8(y[CH_ETH]);
                    if (!err[CH_MF] && primed[CH_MF])
                        massflow <= sat_12(y[CH_MF]);
                    if (!err[CH_TEMP] && primed[CH_TEMP])
                        temperature <= y[CH_TEMP];
                    chan_err     <= err;
                    sample_valid <= 1'b1;
                    if (|err) begin
                        good_cnt <= '0;
                        if (bad_cnt != 4'hF) bad_cnt <= bad_cnt + 4'd1;
                        if (bad_cnt >= PERSIST_M1) fault <= 1'b1;
                    end else begin
                        bad_cnt <= '0;
                        if (good_cnt != 4'hF) good_cnt <= good_cnt + 4'd1;
                        if (good_cnt >= PERSIST_M1) fault <= 1'b0;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/furnace_sensor_scan.md
Name: furnace_sensor_scan

Overview:
Upstream acquisition stage for the furnace controller. Scans four ADC channels (CO, ethanol, massflow, temperature) over a request/acknowledge handshake and smooths each channel with a first-order IIR filter. Saturates each channel to the controller's input widths. Drives the controller's `fault` input with persistence-filtered fault detection (ADC timeout or open-circuit code).

Parameters:
- SCAN_DIV, 1000: clk cycles between scan starts; counter width 16 bits, legal range 8..65535.
- ACK_TIMEOUT, 64: max cycles waiting for adc_ack per channel; counter width 8 bits, legal range 1..255.
- FILT_SHIFT, 2: IIR shift k, y += (x - y) >>> k; legal range 0..4.
- FAULT_PERSIST, 3: consecutive bad scans to set fault, and consecutive good scans to clear it; counter width 4 bits, legal range 1..15.

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-high reset.
- adc_req, out, 1: conversion request, held until ack or timeout.
- adc_ch, out, 2: channel select (0=CO, 1=ethanol, 2=massflow, 3=temperature); stable while adc_req=1.
- adc_ack, in, 1: one-cycle pulse; adc_data is valid in the same cycle.
- adc_data, in, 16: raw unsigned conversion result.
- CO, out, 8: filtered CO, saturated.
- ethanol, out, 8: filtered ethanol, saturated.
- massflow, out, 12: filtered massflow, saturated.
- temperature, out, 16: filtered temperature.
- fault, out, 1: persistent sensor fault.
- sample_valid, out, 1: one-cycle pulse when outputs update.
- chan_err, out, 4: per-channel error flags of the last completed scan.

Behaviour:
- Reset values: all outputs 0, filter state 0, primed flags 0, scan counter 0, FSM in IDLE. Reset mid-scan aborts the scan immediately; no output updates.
- Scan tick: the free-running counter counts 0..SCAN_DIV-1 and pulses tick on wrap. A tick that arrives while a scan is in progress is dropped (no queuing).
- FSM states:
  - IDLE: on tick, ch=0, clear the scan error vector, go to REQ.
  - REQ: adc_req=1 and adc_ch=ch; the timeout counter increments each cycle.
    - If adc_ack=1: go to FILT with adc_data captured.
    - Else if the counter reaches ACK_TIMEOUT-1: set err[ch], drop adc_req, go to NEXT.
    - adc_req drops in the cycle after the ack.
  - FILT (1 cycle):
    - If the captured value is 16'hFFFF (open circuit): set err[ch] and leave the filter unchanged.
    - Else if the channel is unprimed: y = x, and set primed.
    - Else: y = y + ((x - y) >>> FILT_SHIFT), computed as 17-bit signed arithmetic with an arithmetic shift; the result is always within 0..65535.
    - Go to NEXT.
  - NEXT: if ch==3 go to PUB, else ch+1 and go to REQ.
  - PUB (1 cycle):
    - Load outputs: CO = min(y0,255), ethanol = min(y1,255), massflow = min(y2,4095), temperature = y3.
    - Outputs for an errored or unprimed channel hold their previous value.
    - chan_err = err vector; sample_valid=1 for this cycle only.
    - Update fault persistence, then go to IDLE.
- Fault persistence: on PUB, a scan is bad if |err, good otherwise.
  - A bad scan clears good_cnt and increments bad_cnt (saturating). When bad_cnt reaches FAULT_PERSIST, fault=1.
  - A good scan clears bad_cnt and increments good_cnt. When good_cnt reaches FAULT_PERSIST, fault=0.
  - fault changes only in PUB cycles.
- An adc_ack outside REQ is ignored.
- Worst-case scan latency: 4*(ACK_TIMEOUT+2)+1 cycles, which must be < SCAN_DIV.

Decomposition:
- Shared package furnace_pkg holds:
  - channel index constants CH_CO=0, CH_ETH=1, CH_MF=2, CH_TEMP=3;
  - ADC_OPEN=16'hFFFF;
  - the scan FSM state encoding;
  - the saturation limits 255 and 4095.
- One sub-module, sensor_iir_filter, holds a single channel's y register, primed flag and update arithmetic. It is instantiated 4 times, with its enable driven by FILT and ch.

Test Plan:
- Prime: adc model acks after 3 cycles with data 40, 80, 20, 300 → first sample_valid gives CO=40, ethanol=80, massflow=20, temperature=300, chan_err=0, fault=0.
- IIR/saturation: with primed CO=40 and FILT_SHIFT=2, feed CO=200 → CO=80; feed 16'h1000 on the CO channel repeatedly → CO saturates at 255 and never wraps; massflow fed 16'h2000 → 4095.
- Timeout: ethanol channel never acks → adc_req drops after 64 cycles, chan_err=4'b0010, ethanol holds its old value, the scan continues to massflow.
- Fault persistence: temperature channel returns 16'hFFFF for 3 scans → fault rises at the 3rd PUB, not the 2nd. Then 2 good scans → fault stays 1; 3rd good scan → fault=0. An interleaved bad scan restarts the good count.
- Reset mid-scan: assert reset while adc_req=1 on ch=2 → adc_req=0 and all outputs 0 asynchronously; after release, the first tick restarts at ch=0 and the filters re-prime (y=x).
- Tick overlap: SCAN_DIV=8 with slow acks → extra ticks are dropped, one sample_valid per completed scan, no channel is skipped.
